// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: memory op codes, FSM states
// and the pipeline stall bus.
package mem_stage_lsu_pkg;

  typedef enum logic [2:0] {
    MEM_NONE  = 3'd0,
    MEM_LB    = 3'd1,
    MEM_LBU   = 3'd2,
    MEM_LH    = 3'd3,
    MEM_LHU   = 3'd4,
    MEM_LW    = 3'd5,
    MEM_LWU   = 3'd6,
    MEM_STORE = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  localparam int STALL_W   = 6;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  function automatic logic isLoad(input mem_op_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWU};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword/word lane out of
// the SRAM word, extends it, and flags misaligned halfword/word loads.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int ALO_W  = $clog2(DATA_W / 8)
) (
  input  mem_op_e           op_i,
  input  logic [ALO_W-1:0]  addr_lo_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic [7:0]        byteLane;
  logic [15:0]       halfLane;
  logic [DATA_W-1:0] wordSext;
  logic [DATA_W-1:0] wordZext;

  assign byteLane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign halfLane = rdata_i[{addr_lo_i[ALO_W-1:1], 4'b0000} +: 16];

  // On a 32-bit datapath a word load is the whole bus, so LWU behaves as LW.
  generate
    if (DATA_W == 64) begin : gWide
      logic [31:0] wordLane;
      assign wordLane = rdata_i[{addr_lo_i[ALO_W-1], 5'b00000} +: 32];
      assign wordSext = {{32{wordLane[31]}}, wordLane};
      assign wordZext = {32'b0, wordLane};
    end else begin : gNarrow
      assign wordSext = rdata_i;
      assign wordZext = rdata_i;
    end
  endgenerate

  always_comb begin
    data_o       = rdata_i;
    misaligned_o = 1'b0;
    case (op_i)
      MEM_LB:  data_o = {{(DATA_W-8){byteLane[7]}}, byteLane};
      MEM_LBU: data_o = {{(DATA_W-8){1'b0}}, byteLane};
      MEM_LH: begin
        data_o       = {{(DATA_W-16){halfLane[15]}}, halfLane};
        misaligned_o = addr_lo_i[0];
      end
      MEM_LHU: begin
        data_o       = {{(DATA_W-16){1'b0}}, halfLane};
        misaligned_o = addr_lo_i[0];
      end
      MEM_LW: begin
        data_o       = wordSext;
        misaligned_o = |addr_lo_i[1:0];
      end
      MEM_LWU: begin
        data_o       = wordZext;
        misaligned_o = |addr_lo_i[1:0];
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: captures the EX result, stalls for variable-latency load
// data, drains responses orphaned by a flush, and drives WB and ID forwarding.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int PC_W   = 32,
  parameter  int RF_AW  = 5,
  localparam int ALO_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  stall_bus_t        stall_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  input  logic [PC_W-1:0]   ex_pc_i,
  input  mem_op_e           ex_mem_op_i,
  input  logic [ALO_W-1:0]  ex_addr_lo_i,
  input  logic              ex_rf_we_i,
  input  logic [RF_AW-1:0]  ex_rf_waddr_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic              data_sram_rvalid_i,
  input  logic [DATA_W-1:0] data_sram_rdata_i,
  output logic              stallreq_mem_o,
  output logic              wb_valid_o,
  output logic [PC_W-1:0]   wb_pc_o,
  output logic              wb_rf_we_o,
  output logic [RF_AW-1:0]  wb_rf_waddr_o,
  output logic [DATA_W-1:0] wb_rf_wdata_o,
  output logic              wb_adel_o,
  output logic              fwd_we_o,
  output logic [RF_AW-1:0]  fwd_waddr_o,
  output logic [DATA_W-1:0] fwd_wdata_o,
  output logic              fwd_load_pending_o
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    mem_op_e           memOp;
    logic [ALO_W-1:0]  addrLo;
    logic              rfWe;
    logic [RF_AW-1:0]  rfWaddr;
    logic [DATA_W-1:0] result;
  } capture_t;

  capture_t          capture_q, capture_d;
  lsu_state_e        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;

  logic              stallMem, stallWb;
  logic              misaligned, loadPending, loadWaiting, captureAdvance;
  logic [DATA_W-1:0] alignSrc, alignData;
  logic              unusedStallBits;

  assign stallMem        = (stall_i[STALL_MEM] == STOP);
  assign stallWb         = (stall_i[STALL_WB] == STOP);
  assign unusedStallBits = ^{stall_i[STALL_W-1], stall_i[2:0]};

  assign loadPending = capture_q.valid & isLoad(capture_q.memOp) & ~misaligned;
  assign loadWaiting = loadPending & ~data_sram_rvalid_i &
                       ((state_q == ST_IDLE) | (state_q == ST_WAIT));

  assign stallreq_mem_o = loadWaiting | (state_q == ST_DRAIN);
  assign captureAdvance = ~flush_i & ~stallreq_mem_o & (~stallMem | ~stallWb);

  assign alignSrc = (state_q == ST_HOLD) ? rdata_q : data_sram_rdata_i;

  mem_stage_lsu_load_align #(
    .DATA_W (DATA_W)
  ) uAlign (
    .op_i         (capture_q.memOp),
    .addr_lo_i    (capture_q.addrLo),
    .rdata_i      (alignSrc),
    .data_o       (alignData),
    .misaligned_o (misaligned)
  );

  // While this stage requests the stall itself, the waiting load must stay put
  // even though the stall controller signals Stop on MEM with NoStop on WB.
  always_comb begin
    capture_d = capture_q;
    if (flush_i) begin
      capture_d = '0;
    end else if (!stallreq_mem_o) begin
      if (!stallMem) begin
        capture_d.valid   = ex_valid_i;
        capture_d.pc      = ex_pc_i;
        capture_d.memOp   = ex_mem_op_i;
        capture_d.addrLo  = ex_addr_lo_i;
        capture_d.rfWe    = ex_rf_we_i;
        capture_d.rfWaddr = ex_rf_waddr_i;
        capture_d.result  = ex_result_i;
      end else if (!stallWb) begin
        capture_d = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i) begin
          if (loadWaiting) begin
            state_d = ST_WAIT;
          end else if (loadPending && data_sram_rvalid_i && !captureAdvance) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          state_d = data_sram_rvalid_i ? ST_IDLE : ST_DRAIN;
        end else if (data_sram_rvalid_i) begin
          state_d = captureAdvance ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush_i || captureAdvance) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (data_sram_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      capture_q <= '0;
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
    end else begin
      capture_q <= capture_d;
      state_q   <= state_d;
      if (data_sram_rvalid_i && (state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
        rdata_q <= data_sram_rdata_i;
      end
    end
  end

  assign wb_valid_o    = capture_q.valid & ~loadWaiting & (state_q != ST_DRAIN);
  assign wb_pc_o       = capture_q.pc;
  assign wb_rf_we_o    = capture_q.valid & capture_q.rfWe & ~misaligned;
  assign wb_rf_waddr_o = capture_q.rfWaddr;
  assign wb_rf_wdata_o = isLoad(capture_q.memOp) ? alignData : capture_q.result;
  assign wb_adel_o     = capture_q.valid & misaligned;

  assign fwd_we_o           = wb_rf_we_o & wb_valid_o;
  assign fwd_waddr_o        = wb_rf_waddr_o;
  assign fwd_wdata_o        = wb_rf_wdata_o;
  assign fwd_load_pending_o = loadWaiting;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected WB handoffs go into a scoreboard
// queue that a negedge monitor drains; cycle-specific behaviour is checked inline.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  stall_bus_t  stall;
  logic        flush;
  logic        exValid;
  logic [31:0] exPc;
  mem_op_e     exMemOp;
  logic [1:0]  exAddrLo;
  logic        exRfWe;
  logic [4:0]  exRfWaddr;
  logic [31:0] exResult;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stallWbReq;

  logic        stallreqMem;
  logic        wbValid;
  logic [31:0] wbPc;
  logic        wbRfWe;
  logic [4:0]  wbRfWaddr;
  logic [31:0] wbRfWdata;
  logic        wbAdel;
  logic        fwdWe;
  logic [4:0]  fwdWaddr;
  logic [31:0] fwdWdata;
  logic        fwdLoadPending;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        adel;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;

  // Stages 0..3 stop on the MEM stall request or a WB stall; WB stops only on its own.
  assign stall[5]   = NO_STOP;
  assign stall[4]   = stallWbReq ? STOP : NO_STOP;
  assign stall[3:0] = {4{(stallreqMem | stallWbReq) ? STOP : NO_STOP}};

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk_i              (clk),
    .rst_ni             (rstN),
    .stall_i            (stall),
    .flush_i            (flush),
    .ex_valid_i         (exValid),
    .ex_pc_i            (exPc),
    .ex_mem_op_i        (exMemOp),
    .ex_addr_lo_i       (exAddrLo),
    .ex_rf_we_i         (exRfWe),
    .ex_rf_waddr_i      (exRfWaddr),
    .ex_result_i        (exResult),
    .data_sram_rvalid_i (rvalid),
    .data_sram_rdata_i  (rdata),
    .stallreq_mem_o     (stallreqMem),
    .wb_valid_o         (wbValid),
    .wb_pc_o            (wbPc),
    .wb_rf_we_o         (wbRfWe),
    .wb_rf_waddr_o      (wbRfWaddr),
    .wb_rf_wdata_o      (wbRfWdata),
    .wb_adel_o          (wbAdel),
    .fwd_we_o           (fwdWe),
    .fwd_waddr_o        (fwdWaddr),
    .fwd_wdata_o        (fwdWdata),
    .fwd_load_pending_o (fwdLoadPending)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic adel);
    exp_t e;
    e.pc    = pc;
    e.we    = we;
    e.waddr = waddr;
    e.wdata = wdata;
    e.adel  = adel;
    expQ.push_back(e);
  endtask

  // Presents one instruction from EX for a single edge; caller ensures MEM is not stalled.
  task automatic applyStimulus(input logic [31:0] pc, input mem_op_e op, input logic [1:0] k,
                               input logic we, input logic [4:0] waddr,
                               input logic [31:0] result);
    exValid   = 1'b1;
    exPc      = pc;
    exMemOp   = op;
    exAddrLo  = k;
    exRfWe    = we;
    exRfWaddr = waddr;
    exResult  = result;
    step();
    exValid  = 1'b0;
    exMemOp  = MEM_NONE;
    exRfWe   = 1'b0;
    exAddrLo = 2'd0;
  endtask

  task automatic zeroLatLoad(input logic [31:0] pc, input mem_op_e op, input logic [1:0] k,
                             input logic [4:0] waddr, input logic [31:0] expected);
    pushExp(pc, 1'b1, waddr, expected, 1'b0);
    applyStimulus(pc, op, k, 1'b1, waddr, 32'h0BAD0BAD);
    rvalid = 1'b1;
    rdata  = 32'h80FF7F01;
    @(negedge clk);
    checkOutput("zero_lat_stallreq", stallreqMem, 1'b0);
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
  endtask

  always @(negedge clk) begin
    if (rstN && wbValid && (stall[4] == NO_STOP)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_wb: got handoff pc 0x%0h wdata 0x%0h, expected none",
                 wbPc, wbRfWdata);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("wb_pc", wbPc, monExp.pc);
        checkOutput("wb_rf_we", wbRfWe, monExp.we);
        checkOutput("wb_adel", wbAdel, monExp.adel);
        checkOutput("fwd_we", fwdWe, monExp.we);
        if (monExp.we) begin
          checkOutput("wb_rf_waddr", wbRfWaddr, monExp.waddr);
          checkOutput("wb_rf_wdata", wbRfWdata, monExp.wdata);
          checkOutput("fwd_wdata", fwdWdata, monExp.wdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN       = 1'b0;
    flush      = 1'b0;
    exValid    = 1'b0;
    exPc       = 32'h0;
    exMemOp    = MEM_NONE;
    exAddrLo   = 2'd0;
    exRfWe     = 1'b0;
    exRfWaddr  = 5'd0;
    exResult   = 32'h0;
    rvalid     = 1'b0;
    rdata      = 32'h0;
    stallWbReq = 1'b0;

    #12;
    checkOutput("reset_wb_valid", wbValid, 1'b0);
    checkOutput("reset_stallreq", stallreqMem, 1'b0);
    checkOutput("reset_wdata", wbRfWdata, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    step();

    // LW with three cycles of SRAM latency
    $display("[TB] LW with 3-cycle latency");
    pushExp(32'h100, 1'b1, 5'd3, 32'h8899AABB, 1'b0);
    applyStimulus(32'h100, MEM_LW, 2'd0, 1'b1, 5'd3, 32'hDEAD0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("lat_stallreq", stallreqMem, 1'b1);
      checkOutput("lat_pending", fwdLoadPending, 1'b1);
      checkOutput("lat_wb_valid", wbValid, 1'b0);
      step();
    end
    rvalid = 1'b1;
    rdata  = 32'h8899AABB;
    @(negedge clk);
    checkOutput("lat_stallreq_drop", stallreqMem, 1'b0);
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;

    // Zero-latency sub-word loads of 0x80FF7F01, plus ALU and store passthrough
    $display("[TB] zero-latency sub-word loads");
    zeroLatLoad(32'h200, MEM_LB,  2'd3, 5'd1, 32'hFFFFFF80);
    zeroLatLoad(32'h204, MEM_LBU, 2'd1, 5'd2, 32'h0000007F);
    zeroLatLoad(32'h208, MEM_LH,  2'd2, 5'd3, 32'hFFFF80FF);
    zeroLatLoad(32'h20C, MEM_LHU, 2'd0, 5'd4, 32'h00007F01);
    zeroLatLoad(32'h210, MEM_LW,  2'd0, 5'd5, 32'h80FF7F01);
    zeroLatLoad(32'h214, MEM_LBU, 2'd3, 5'd6, 32'h00000080);
    zeroLatLoad(32'h218, MEM_LB,  2'd2, 5'd7, 32'hFFFFFFFF);
    pushExp(32'h220, 1'b1, 5'd10, 32'h12345678, 1'b0);
    applyStimulus(32'h220, MEM_NONE, 2'd0, 1'b1, 5'd10, 32'h12345678);
    @(negedge clk);
    checkOutput("alu_stallreq", stallreqMem, 1'b0);
    step();
    pushExp(32'h224, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(32'h224, MEM_STORE, 2'd2, 1'b0, 5'd0, 32'h0000AAAA);
    @(negedge clk);
    checkOutput("store_stallreq", stallreqMem, 1'b0);
    step();

    // Misaligned loads raise ADEL and never stall
    $display("[TB] misaligned loads");
    pushExp(32'h300, 1'b0, 5'd5, 32'h0, 1'b1);
    applyStimulus(32'h300, MEM_LH, 2'd1, 1'b1, 5'd5, 32'h0);
    @(negedge clk);
    checkOutput("adel_lh_stallreq", stallreqMem, 1'b0);
    checkOutput("adel_lh_pending", fwdLoadPending, 1'b0);
    step();
    pushExp(32'h304, 1'b0, 5'd6, 32'h0, 1'b1);
    applyStimulus(32'h304, MEM_LW, 2'd2, 1'b1, 5'd6, 32'h0);
    @(negedge clk);
    checkOutput("adel_lw_stallreq", stallreqMem, 1'b0);
    step();
    pushExp(32'h308, 1'b0, 5'd7, 32'h0, 1'b1);
    applyStimulus(32'h308, MEM_LHU, 2'd3, 1'b1, 5'd7, 32'h0);
    @(negedge clk);
    checkOutput("adel_lhu_stallreq", stallreqMem, 1'b0);
    step();

    // Flush while waiting: the late response is drained and discarded
    $display("[TB] flush during wait");
    applyStimulus(32'h400, MEM_LW, 2'd0, 1'b1, 5'd6, 32'h0);
    @(negedge clk);
    checkOutput("flush_pre_stallreq", stallreqMem, 1'b1);
    step();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_wait_stallreq", stallreqMem, 1'b1);
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = (i == 1);
      rdata  = (i == 1) ? 32'hBADBAD00 : 32'h0;
      @(negedge clk);
      checkOutput("drain_stallreq", stallreqMem, 1'b1);
      checkOutput("drain_wb_valid", wbValid, 1'b0);
      checkOutput("drain_fwd_we", fwdWe, 1'b0);
      checkOutput("drain_fwd_wdata", fwdWdata, 32'h0);
      step();
    end
    rvalid = 1'b0;
    rdata  = 32'h0;
    @(negedge clk);
    checkOutput("drain_done_stallreq", stallreqMem, 1'b0);
    checkOutput("drain_done_pending", fwdLoadPending, 1'b0);
    step();
    zeroLatLoad(32'h408, MEM_LHU, 2'd2, 5'd8, 32'h000080FF);

    // Response arrives while WB is stalled: value held until WB releases
    $display("[TB] response under WB stall");
    pushExp(32'h500, 1'b1, 5'd7, 32'h11223344, 1'b0);
    applyStimulus(32'h500, MEM_LW, 2'd0, 1'b1, 5'd7, 32'h0);
    @(negedge clk);
    step();
    stallWbReq = 1'b1;
    rvalid     = 1'b1;
    rdata      = 32'h11223344;
    @(negedge clk);
    checkOutput("hold_rvalid_wb_valid", wbValid, 1'b1);
    checkOutput("hold_rvalid_wdata", wbRfWdata, 32'h11223344);
    step();
    rvalid = 1'b0;
    rdata  = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("hold_wb_valid", wbValid, 1'b1);
      checkOutput("hold_wdata", wbRfWdata, 32'h11223344);
      checkOutput("hold_stallreq", stallreqMem, 1'b0);
      step();
    end
    stallWbReq = 1'b0;
    @(negedge clk);
    step();
    rdata = 32'h0;
    @(negedge clk);
    checkOutput("hold_release_wb_valid", wbValid, 1'b0);
    step();

    // Asynchronous reset in the middle of a wait
    $display("[TB] reset during wait");
    applyStimulus(32'h600, MEM_LW, 2'd0, 1'b1, 5'd9, 32'h77);
    step();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_stallreq", stallreqMem, 1'b0);
    checkOutput("arst_wb_valid", wbValid, 1'b0);
    checkOutput("arst_wb_pc", wbPc, 32'h0);
    checkOutput("arst_wb_rf_we", wbRfWe, 1'b0);
    checkOutput("arst_wb_waddr", wbRfWaddr, 5'd0);
    checkOutput("arst_wb_wdata", wbRfWdata, 32'h0);
    checkOutput("arst_wb_adel", wbAdel, 1'b0);
    checkOutput("arst_fwd_we", fwdWe, 1'b0);
    checkOutput("arst_fwd_waddr", fwdWaddr, 5'd0);
    checkOutput("arst_fwd_wdata", fwdWdata, 32'h0);
    checkOutput("arst_pending", fwdLoadPending, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    step();
    @(negedge clk);
    checkOutput("post_rst_stallreq", stallreqMem, 1'b0);
    checkOutput("post_rst_wb_valid", wbValid, 1'b0);
    step();
    zeroLatLoad(32'h604, MEM_LH, 2'd0, 5'd11, 32'h00007F01);
    step();

    checkOutput("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
